// File: rtl/lane_scrambler_if.sv
`default_nettype none
// ============================================================================
// lane_scrambler_if
// Symbol bus between a lane's symbol source and the lane scrambler.
// Revision: 1.0
// ============================================================================

interface lane_scrambler_if;
  logic [2:0]  GEN;
  logic [5:0]  PIPEWIDTH;
  logic [31:0] dataIn;
  logic [3:0]  dataK;
  logic        dataValid;
  logic [1:0]  syncHeader;
  logic        startBlock;
  logic        turnOff;
  logic [23:0] seedValue;

  logic [31:0] txData;
  logic [3:0]  txDataK;
  logic        txDataValid;
  logic [1:0]  txSyncHeader;
  logic        txStartBlock;

  modport master (
    output GEN, PIPEWIDTH, dataIn, dataK, dataValid, syncHeader, startBlock,
           turnOff, seedValue,
    input  txData, txDataK, txDataValid, txSyncHeader, txStartBlock
  );

  modport slave (
    input  GEN, PIPEWIDTH, dataIn, dataK, dataValid, syncHeader, startBlock,
           turnOff, seedValue,
    output txData, txDataK, txDataValid, txSyncHeader, txStartBlock
  );
endinterface

`default_nettype wire

// File: rtl/lane_scrambler.sv
`default_nettype none
// ============================================================================
// lane_scrambler
// Per-lane scrambler: Gen1/2 16-bit LFSR with K-symbol rules, Gen3+ 23-bit
// LFSR with 128b/130b block tracking. Single registered stage.
// Revision: 1.0
// ============================================================================

module lane_scrambler #(
  parameter logic [15:0] GEN1_SEED = 16'hFFFF,
  parameter logic [7:0]  SKP_SYM   = 8'hAA
) (
  input wire              clk,
  input wire              reset,
  lane_scrambler_if.slave bus
);

  localparam logic [15:0] c_POLY16   = 16'h0039;
  localparam logic [22:0] c_POLY23   = 23'h210125;
  localparam logic [7:0]  c_COM      = 8'hBC;
  localparam logic [7:0]  c_SKP1     = 8'h1C;
  localparam logic [7:0]  c_EIEOS    = 8'h00;
  localparam logic [1:0]  c_HDR_DATA = 2'b01;

  // Serial Galois LFSR run for one byte; key bit i is the MSB before shift i.
  function automatic logic [23:0] f_scr16(input logic [15:0] s);
    logic [15:0] st;
    logic [7:0]  key;
    st  = s;
    key = '0;
    for (int i = 0; i < 8; i++) begin
      key[i] = st[15];
      st     = {st[14:0], 1'b0} ^ (st[15] ? c_POLY16 : 16'h0000);
    end
    return {key, st};
  endfunction

  function automatic logic [30:0] f_scr23(input logic [22:0] s);
    logic [22:0] st;
    logic [7:0]  key;
    st  = s;
    key = '0;
    for (int i = 0; i < 8; i++) begin
      key[i] = st[22];
      st     = {st[21:0], 1'b0} ^ (st[22] ? c_POLY23 : 23'h000000);
    end
    return {key, st};
  endfunction

  logic [15:0] r_lfsr16, w_lfsr16;
  logic [22:0] r_lfsr23, w_lfsr23;
  logic [3:0]  r_count, w_count;
  logic [1:0]  r_hdr, w_hdr;
  logic        r_skpBlock, w_skpBlock;
  logic        r_eieosBlock, w_eieosBlock;
  logic [2:0]  r_lastGen, w_lastGen;

  logic [31:0] r_txData, w_txData;
  logic [3:0]  r_txDataK, w_txDataK;
  logic        r_txDataValid, w_txDataValid;
  logic [1:0]  r_txSyncHeader, w_txSyncHeader;
  logic        r_txStartBlock, w_txStartBlock;

  logic [3:0]  w_laneEn;
  logic [3:0]  w_nBytes;
  logic        w_gen3;
  logic        w_genChange;
  logic [7:0]  w_sym;
  logic [3:0]  w_symIdx;
  logic [23:0] w_step16;
  logic [30:0] w_step23;
  logic [4:0]  w_unusedBits;

  assign w_laneEn     = bus.PIPEWIDTH[5] ? 4'hF : (bus.PIPEWIDTH[4] ? 4'h3 : 4'h1);
  assign w_nBytes     = bus.PIPEWIDTH[5] ? 4'd4 : (bus.PIPEWIDTH[4] ? 4'd2 : 4'd1);
  assign w_gen3       = (bus.GEN >= 3'd3);
  assign w_genChange  = (bus.GEN != r_lastGen);
  assign w_unusedBits = {bus.seedValue[23], bus.PIPEWIDTH[3:0]};

  always_comb begin
    w_lfsr16       = r_lfsr16;
    w_lfsr23       = r_lfsr23;
    w_count        = r_count;
    w_hdr          = r_hdr;
    w_skpBlock     = r_skpBlock;
    w_eieosBlock   = r_eieosBlock;
    w_lastGen      = r_lastGen;
    w_txData       = '0;
    w_txDataK      = '0;
    w_txDataValid  = 1'b0;
    w_txSyncHeader = '0;
    w_txStartBlock = 1'b0;
    w_sym          = '0;
    w_symIdx       = '0;
    w_step16       = '0;
    w_step23       = '0;

    if (bus.dataValid) begin
      w_lastGen     = bus.GEN;
      w_txDataValid = 1'b1;
      // A rate change restarts the relevant LFSR before this cycle's bytes.
      if (w_genChange) begin
        w_count = '0;
        if (w_gen3) w_lfsr23 = bus.seedValue[22:0];
        else        w_lfsr16 = GEN1_SEED;
      end

      if (!w_gen3) begin
        for (int b = 0; b < 4; b++) begin
          if (w_laneEn[b]) begin
            w_sym    = bus.dataIn[8*b +: 8];
            w_step16 = f_scr16(w_lfsr16);
            if (!bus.turnOff) begin
              if (bus.dataK[b] && (w_sym == c_COM)) begin
                w_lfsr16 = GEN1_SEED;
              end else if (!(bus.dataK[b] && (w_sym == c_SKP1))) begin
                w_lfsr16 = w_step16[15:0];
                if (!bus.dataK[b]) w_sym = w_sym ^ w_step16[23:16];
              end
            end
            w_txData[8*b +: 8] = w_sym;
            w_txDataK[b]       = bus.dataK[b];
          end
        end
      end else begin
        // Block type is decided once, from symbol 0, and held until the next block.
        if (bus.startBlock) begin
          w_count      = '0;
          w_hdr        = bus.syncHeader;
          w_skpBlock   = (bus.syncHeader != c_HDR_DATA) && (bus.dataIn[7:0] == SKP_SYM);
          w_eieosBlock = (bus.syncHeader != c_HDR_DATA) && (bus.dataIn[7:0] == c_EIEOS);
        end
        w_txSyncHeader = w_hdr;
        w_txStartBlock = bus.startBlock;
        for (int b = 0; b < 4; b++) begin
          if (w_laneEn[b]) begin
            w_sym    = bus.dataIn[8*b +: 8];
            w_symIdx = w_count + 4'(b);
            w_step23 = f_scr23(w_lfsr23);
            if (!bus.turnOff) begin
              if (w_hdr == c_HDR_DATA) begin
                w_sym    = w_sym ^ w_step23[30:23];
                w_lfsr23 = w_step23[22:0];
              end else begin
                if (!w_skpBlock) w_lfsr23 = w_step23[22:0];
                if (w_eieosBlock && (w_symIdx == 4'd15)) w_lfsr23 = bus.seedValue[22:0];
              end
            end
            w_txData[8*b +: 8] = w_sym;
          end
        end
        w_count = w_count + w_nBytes;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr16       <= GEN1_SEED;
      r_lfsr23       <= bus.seedValue[22:0];
      r_count        <= '0;
      r_hdr          <= 2'b00;
      r_skpBlock     <= 1'b0;
      r_eieosBlock   <= 1'b0;
      r_lastGen      <= '0;
      r_txData       <= '0;
      r_txDataK      <= '0;
      r_txDataValid  <= 1'b0;
      r_txSyncHeader <= '0;
      r_txStartBlock <= 1'b0;
    end else begin
      r_lfsr16       <= w_lfsr16;
      r_lfsr23       <= w_lfsr23;
      r_count        <= w_count;
      r_hdr          <= w_hdr;
      r_skpBlock     <= w_skpBlock;
      r_eieosBlock   <= w_eieosBlock;
      r_lastGen      <= w_lastGen;
      r_txData       <= w_txData;
      r_txDataK      <= w_txDataK;
      r_txDataValid  <= w_txDataValid;
      r_txSyncHeader <= w_txSyncHeader;
      r_txStartBlock <= w_txStartBlock;
    end
  end

  assign bus.txData       = r_txData;
  assign bus.txDataK      = r_txDataK;
  assign bus.txDataValid  = r_txDataValid;
  assign bus.txSyncHeader = r_txSyncHeader;
  assign bus.txStartBlock = r_txStartBlock;

endmodule

`default_nettype wire

// File: tb/tb_lane_scrambler.sv
`default_nettype none
// Bench for lane_scrambler: known-answer tables, block-level sequences and
// randomized traffic against a byte-stream reference model.

module tb_lane_scrambler;

  localparam logic [15:0] c_SEED1 = 16'hFFFF;
  localparam logic [7:0]  c_SKP   = 8'hAA;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lane_scrambler_if bus();

  lane_scrambler #(.GEN1_SEED(c_SEED1), .SKP_SYM(c_SKP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int nErrors = 0;
  int nChecks = 0;

  // Reference model state
  logic [15:0] mS16;
  logic [22:0] mS23;
  logic [3:0]  mCnt;
  logic [1:0]  mHdr;
  logic        mSkp, mEie;
  logic [2:0]  mLastGen;
  logic [39:0] expOut;

  typedef struct {
    logic [2:0]  gen;
    logic [5:0]  pw;
    logic        v;
    logic [31:0] d;
    logic [3:0]  k;
    logic [39:0] exp;
  } vec_t;
  vec_t vecs[$];

  logic [31:0] blkIn[4], blkOut[4], dA[4], sA[4], dB[4], sB[4];

  function automatic logic [39:0] actOut();
    return {bus.txDataValid, bus.txSyncHeader, bus.txStartBlock, bus.txDataK, bus.txData};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] want);
    nChecks++;
    if (act !== want) begin
      nErrors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // One byte of a w-bit Galois PRBS; key bit i is the register MSB at step i.
  function automatic logic [31:0] galois8(input logic [31:0] s, input int w,
                                          input logic [31:0] poly, output logic [7:0] key);
    logic [31:0] st, mask;
    logic msb;
    st   = s;
    mask = (32'd1 << w) - 32'd1;
    key  = '0;
    for (int i = 0; i < 8; i++) begin
      msb    = st[w-1];
      key[i] = msb;
      st     = ((st << 1) & mask) ^ (msb ? poly : 32'd0);
    end
    return st;
  endfunction

  task automatic modelReset();
    mS16 = c_SEED1; mS23 = bus.seedValue[22:0]; mCnt = 0; mHdr = 2'b00;
    mSkp = 0; mEie = 0; mLastGen = 0; expOut = '0;
  endtask

  task automatic modelCycle();
    logic [31:0] od;
    logic [3:0]  ok;
    logic [1:0]  oh;
    logic        osb;
    logic [7:0]  sym, key;
    logic        isCom, isSkp;
    int nb;
    od = '0; ok = '0; oh = '0; osb = 0;
    if (!bus.dataValid) begin
      expOut = '0;
      return;
    end
    nb = int'(bus.PIPEWIDTH) / 8;
    if (bus.GEN != mLastGen) begin
      if (bus.GEN <= 3'd2) mS16 = c_SEED1;
      else                 mS23 = bus.seedValue[22:0];
      mCnt = 0;
    end
    mLastGen = bus.GEN;
    if (bus.GEN <= 3'd2) begin
      for (int b = 0; b < nb; b++) begin
        sym   = bus.dataIn[8*b +: 8];
        ok[b] = bus.dataK[b];
        isCom = ok[b] && (sym == 8'hBC);
        isSkp = ok[b] && (sym == 8'h1C);
        if (!bus.turnOff) begin
          if (isCom) mS16 = c_SEED1;
          else if (!isSkp) begin
            mS16 = 16'(galois8({16'd0, mS16}, 16, 32'h39, key));
            if (!ok[b]) sym = sym ^ key;
          end
        end
        od[8*b +: 8] = sym;
      end
    end else begin
      if (bus.startBlock) begin
        mCnt = 0;
        mHdr = bus.syncHeader;
        mSkp = (bus.syncHeader != 2'b01) && (bus.dataIn[7:0] == c_SKP);
        mEie = (bus.syncHeader != 2'b01) && (bus.dataIn[7:0] == 8'h00);
      end
      oh  = mHdr;
      osb = bus.startBlock;
      for (int b = 0; b < nb; b++) begin
        sym = bus.dataIn[8*b +: 8];
        if (!bus.turnOff) begin
          if (mHdr == 2'b01) begin
            mS23 = 23'(galois8({9'd0, mS23}, 23, 32'h210125, key));
            sym  = sym ^ key;
          end else begin
            if (!mSkp) mS23 = 23'(galois8({9'd0, mS23}, 23, 32'h210125, key));
            if (mEie && mCnt == 4'd15) mS23 = bus.seedValue[22:0];
          end
        end
        od[8*b +: 8] = sym;
        mCnt = mCnt + 4'd1;
      end
    end
    expOut = {1'b1, oh, osb, ok, od};
  endtask

  task automatic drive(input logic [2:0] gen, input logic [5:0] pw, input logic v,
                       input logic [31:0] d, input logic [3:0] k, input logic [1:0] hdr,
                       input logic sb, input logic off);
    bus.GEN = gen; bus.PIPEWIDTH = pw; bus.dataValid = v; bus.dataIn = d;
    bus.dataK = k; bus.syncHeader = hdr; bus.startBlock = sb; bus.turnOff = off;
    if (reset) modelReset();
    else       modelCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    drive(3'd1, 6'd8, 1'b0, 32'd0, 4'd0, 2'b00, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic sendBlock(input logic [1:0] hdr, input string name);
    for (int i = 0; i < 4; i++) begin
      drive(3'd3, 6'd32, 1'b1, blkIn[i], 4'd0, hdr, (i == 0), 1'b0);
      check(name, actOut(), expOut);
      blkOut[i] = bus.txData;
    end
  endtask

  task automatic addVec(input logic [2:0] gen, input logic [5:0] pw, input logic v,
                        input logic [31:0] d, input logic [3:0] k,
                        input logic [31:0] ed, input logic [3:0] ek);
    vec_t t;
    t.gen = gen; t.pw = pw; t.v = v; t.d = d; t.k = k;
    t.exp = {v, 3'b000, ek, ed};
    vecs.push_back(t);
  endtask

  initial begin
    logic [22:0] s23;
    logic [7:0]  key, rec;
    logic [31:0] d;
    logic [3:0]  k;
    logic [2:0]  gen;
    logic [5:0]  pw;
    logic [1:0]  hdr;
    logic        sb, kb;

    reset = 1'b1;
    bus.seedValue = 24'h1DBFBC;
    bus.GEN = 3'd1; bus.PIPEWIDTH = 6'd8; bus.dataIn = '0; bus.dataK = '0;
    bus.dataValid = 0; bus.syncHeader = 2'b00; bus.startBlock = 0; bus.turnOff = 0;

    doReset();
    check("resetOut", actOut(), 40'd0);

    // Gen1 x8: COM then D00 stream, with an idle cycle that must hold the LFSR
    addVec(3'd1, 6'd8,  1'b1, 32'hA5A5A5BC, 4'b1111, 32'h000000BC, 4'b0001);
    addVec(3'd1, 6'd8,  1'b1, 32'h12345600, 4'b0000, 32'h000000FF, 4'b0000);
    addVec(3'd1, 6'd8,  1'b0, 32'h00000000, 4'b0000, 32'h00000000, 4'b0000);
    addVec(3'd1, 6'd8,  1'b1, 32'h00000000, 4'b0000, 32'h00000017, 4'b0000);
    addVec(3'd1, 6'd8,  1'b1, 32'h00000000, 4'b0000, 32'h000000C0, 4'b0000);
    addVec(3'd1, 6'd8,  1'b1, 32'h00000000, 4'b0000, 32'h00000014, 4'b0000);
    addVec(3'd1, 6'd8,  1'b1, 32'h00000000, 4'b0000, 32'h000000B2, 4'b0000);
    addVec(3'd1, 6'd8,  1'b1, 32'h00000000, 4'b0000, 32'h000000E7, 4'b0000);
    addVec(3'd1, 6'd8,  1'b1, 32'h00000000, 4'b0000, 32'h00000002, 4'b0000);
    addVec(3'd1, 6'd8,  1'b1, 32'h00000000, 4'b0000, 32'h00000082, 4'b0000);
    // SKP freezes the LFSR
    addVec(3'd1, 6'd8,  1'b1, 32'h000000BC, 4'b0001, 32'h000000BC, 4'b0001);
    addVec(3'd1, 6'd8,  1'b1, 32'h0000001C, 4'b0001, 32'h0000001C, 4'b0001);
    addVec(3'd1, 6'd8,  1'b1, 32'h0000001C, 4'b0001, 32'h0000001C, 4'b0001);
    addVec(3'd1, 6'd8,  1'b1, 32'h0000001C, 4'b0001, 32'h0000001C, 4'b0001);
    addVec(3'd1, 6'd8,  1'b1, 32'h00000000, 4'b0000, 32'h000000FF, 4'b0000);
    addVec(3'd1, 6'd8,  1'b1, 32'h00000000, 4'b0000, 32'h00000017, 4'b0000);
    // Gen2 x16
    addVec(3'd2, 6'd16, 1'b1, 32'h776600BC, 4'b0001, 32'h0000FFBC, 4'b0001);
    addVec(3'd2, 6'd16, 1'b1, 32'h55440000, 4'b0000, 32'h0000C017, 4'b0000);

    foreach (vecs[i]) begin
      drive(vecs[i].gen, vecs[i].pw, vecs[i].v, vecs[i].d, vecs[i].k, 2'b00, 1'b0, 1'b0);
      check($sformatf("vec%0d", i), actOut(), vecs[i].exp);
    end

    // Gen3 data / EIEOS / data, and descrambling with the same seed
    bus.seedValue = 24'h1DBFBC;
    doReset();
    for (int i = 0; i < 4; i++) begin dA[i] = $urandom; blkIn[i] = dA[i]; end
    sendBlock(2'b01, "g3dataA");
    for (int i = 0; i < 4; i++) sA[i] = blkOut[i];
    for (int i = 0; i < 4; i++) blkIn[i] = 32'hFF00FF00;
    sendBlock(2'b10, "g3eieos");
    for (int i = 0; i < 4; i++) check("eieosPass", {8'd0, blkOut[i]}, {8'd0, blkIn[i]});
    for (int i = 0; i < 4; i++) blkIn[i] = dA[i];
    sendBlock(2'b01, "g3dataPost");
    for (int i = 0; i < 4; i++) check("postEieosSame", {8'd0, blkOut[i]}, {8'd0, sA[i]});
    s23 = 23'h1DBFBC;
    for (int i = 0; i < 4; i++) begin
      d = '0;
      for (int b = 0; b < 4; b++) begin
        s23 = 23'(galois8({9'd0, s23}, 23, 32'h210125, key));
        rec = sA[i][8*b +: 8] ^ key;
        d[8*b +: 8] = rec;
      end
      check("descramble", {8'd0, d}, {8'd0, dA[i]});
    end

    // SKP ordered set between data blocks leaves the LFSR untouched
    doReset();
    for (int i = 0; i < 4; i++) begin dA[i] = $urandom; dB[i] = $urandom; blkIn[i] = dA[i]; end
    sendBlock(2'b01, "refA");
    for (int i = 0; i < 4; i++) blkIn[i] = dB[i];
    sendBlock(2'b01, "refB");
    for (int i = 0; i < 4; i++) sB[i] = blkOut[i];
    doReset();
    for (int i = 0; i < 4; i++) blkIn[i] = dA[i];
    sendBlock(2'b01, "skpA");
    for (int i = 0; i < 4; i++) blkIn[i] = $urandom;
    blkIn[0][7:0] = c_SKP;
    sendBlock(2'b10, "skpOS");
    for (int i = 0; i < 4; i++) check("skpPass", {8'd0, blkOut[i]}, {8'd0, blkIn[i]});
    for (int i = 0; i < 4; i++) blkIn[i] = dB[i];
    sendBlock(2'b01, "skpB");
    for (int i = 0; i < 4; i++) check("afterSkpSame", {8'd0, blkOut[i]}, {8'd0, sB[i]});

    // Reset mid-block at counter 8, then Gen1
    doReset();
    drive(3'd3, 6'd32, 1'b1, $urandom, 4'd0, 2'b01, 1'b1, 1'b0);
    drive(3'd3, 6'd32, 1'b1, $urandom, 4'd0, 2'b01, 1'b0, 1'b0);
    reset = 1'b1;
    drive(3'd1, 6'd8, 1'b1, 32'h000000BC, 4'b0001, 2'b00, 1'b0, 1'b0);
    check("midReset", actOut(), 40'd0);
    reset = 1'b0;
    drive(3'd1, 6'd8, 1'b1, 32'h000000BC, 4'b0001, 2'b00, 1'b0, 1'b0);
    check("postResetCom", actOut(), {1'b1, 3'b000, 4'b0001, 32'h000000BC});
    drive(3'd1, 6'd8, 1'b1, 32'h00000000, 4'b0000, 2'b00, 1'b0, 1'b0);
    check("postResetD00", actOut(), {1'b1, 3'b000, 4'b0000, 32'h000000FF});

    // Randomized traffic in segments of varying rate and width
    doReset();
    for (int seg = 0; seg < 14; seg++) begin
      gen = 3'($urandom_range(1, 5));
      case ($urandom_range(0, 2))
        0:       pw = 6'd8;
        1:       pw = 6'd16;
        default: pw = 6'd32;
      endcase
      bus.seedValue = 24'($urandom);
      for (int c = 0; c < 45; c++) begin
        d = $urandom; k = '0; hdr = 2'b00; sb = 0;
        if (gen <= 3'd2) begin
          for (int b = 0; b < 4; b++) begin
            kb = ($urandom_range(0, 3) == 0);
            k[b] = kb;
            if (kb) begin
              case ($urandom_range(0, 3))
                0: d[8*b +: 8] = 8'hBC;
                1: d[8*b +: 8] = 8'h1C;
                2: d[8*b +: 8] = 8'hF7;
                default: ;
              endcase
            end
          end
        end else begin
          sb  = ($urandom_range(0, 5) == 0);
          hdr = $urandom_range(0, 1) ? 2'b01 : 2'b10;
          if (sb && hdr == 2'b10) begin
            case ($urandom_range(0, 2))
              0: d[7:0] = c_SKP;
              1: d[7:0] = 8'h00;
              default: ;
            endcase
          end
        end
        drive(gen, pw, ($urandom_range(0, 99) < 85), d, k, hdr, sb,
              ($urandom_range(0, 99) < 8));
        check("random", actOut(), expOut);
      end
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

`default_nettype wire
